// File: rtl/writeback.sv
// rtl/writeback.sv - writeback stage with an in-order pending-write buffer in front of the register file
module writeback #(
    parameter int WORD  = 32,
    parameter int W_RD  = 5,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            v_i,
    output logic            stall_o,
    input  logic            wb_i,
    input  logic [W_RD-1:0] rd_num_i,
    input  logic [WORD-1:0] rd_data_i,
    input  logic            rf_busy_i,
    output logic            rf_we_o,
    output logic [W_RD-1:0] rf_num_o,
    output logic [WORD-1:0] rf_data_o,
    input  logic [W_RD-1:0] chk_num_i,
    output logic            hit_o,
    output logic [WORD-1:0] hit_data_o,
    output logic [15:0]     ret_cnt_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     ret_q, ret_d;
    logic [W_RD-1:0] num_q  [DEPTH];
    logic [W_RD-1:0] num_d  [DEPTH];
    logic [WORD-1:0] data_q [DEPTH];
    logic [WORD-1:0] data_d [DEPTH];

    logic            accept;
    logic            push;
    logic            pop;
    logic            retire_now;
    logic            not_empty;
    logic [PW-1:0]   idx;

    // Status and write-port signals depend on registered state only, so the
    // execute stage never sees a combinational path from its own inputs.
    always_comb begin
        not_empty  = (count_q != '0);
        stall_o    = (count_q == CW'(DEPTH));
        accept     = v_i & ~stall_o;
        push       = accept & wb_i & (rd_num_i != '0);
        retire_now = accept & ~push;
        pop        = not_empty & ~rf_busy_i;
        rf_we_o    = pop;
        rf_num_o   = not_empty ? num_q[head_q]  : '0;
        rf_data_o  = not_empty ? data_q[head_q] : '0;
    end

    // Scan oldest to youngest so the last valid match (the youngest) wins.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (num_q[idx] == chk_num_i)) begin
                hit_o      = 1'b1;
                hit_data_o = data_q[idx];
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        num_d   = num_q;
        data_d  = data_q;
        ret_d   = ret_q + {15'd0, retire_now} + {15'd0, pop};
        if (push) begin
            num_d[tail_q]  = rd_num_i;
            data_d[tail_q] = rd_data_i;
            tail_d         = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    assign ret_cnt_o = ret_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ret_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                num_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ret_q   <= ret_d;
            num_q   <= num_d;
            data_q  <= data_d;
        end
    end
endmodule
